// File: rtl/rect_plot_if.sv
// rect_plot_if: command queue handshake and vga_adapter pixel bus of the rectangle engine
interface rect_plot_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [X_W-1:0]     cmd_w;
    logic [Y_W-1:0]     cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               cmd_mode;
    logic [X_W-1:0]     plot_x;
    logic [Y_W-1:0]     plot_y;
    logic [COLOR_W-1:0] color;
    logic               plot;
    logic               busy;
    logic               done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode,
        input  cmd_ready, plot_x, plot_y, color, plot, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode,
        output cmd_ready, plot_x, plot_y, color, plot, busy, done
    );
endinterface

// File: rtl/rect_plot_engine.sv
// rect_plot_engine: queued fill/outline rectangle rasteriser emitting one clipped pixel
// position per cycle onto the vga_adapter plot bus, with a per-command done pulse
module rect_plot_engine #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOR_W    = 3,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FIFO_DEPTH = 4
) (
    input logic        clk,
    input logic        reset,
    rect_plot_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 2 * X_W + 2 * Y_W + COLOR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count, count_n;
    logic               push, pop;
    logic [X_W-1:0]     hx, hw, x, w, cnt_i;
    logic [Y_W-1:0]     hy, hh, y, h, cnt_j;
    logic [COLOR_W-1:0] hc, c;
    logic               hm, mode;
    logic [X_W:0]       sx;
    logic [Y_W:0]       sy;
    logic               hempty, on, last_i, last_j, rim, draw_px;

    assign push    = bus.cmd_valid & bus.cmd_ready;
    assign pop     = state == LOAD;
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    assign {hm, hc, hh, hw, hy, hx} = mem[rd_ptr];
    assign hempty  = hw == '0 || hh == '0;
    // one extra bit so a carry past the coordinate width counts as off-screen
    assign sx      = {1'b0, x} + {1'b0, cnt_i};
    assign sy      = {1'b0, y} + {1'b0, cnt_j};
    assign on      = sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H);
    assign last_i  = cnt_i == w - X_W'(1);
    assign last_j  = cnt_j == h - Y_W'(1);
    assign rim     = !mode || cnt_i == '0 || last_i || cnt_j == '0 || last_j;
    assign draw_px = state == DRAW && on && rim;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = count != '0 ? LOAD : IDLE;
            LOAD:    state_n = !hempty ? DRAW : (count > (AW+1)'(1) ? LOAD : IDLE);
            DRAW:    state_n = !(last_i && last_j) ? DRAW : (count != '0 ? LOAD : IDLE);
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.cmd_mode, bus.cmd_color, bus.cmd_h, bus.cmd_w, bus.cmd_y, bus.cmd_x};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count         <= count_n;
            bus.cmd_ready <= count_n != (AW+1)'(FIFO_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.plot   <= 1'b0;
            bus.plot_x <= '0;
            bus.plot_y <= '0;
            bus.color  <= '0;
            bus.done   <= 1'b0;
            bus.busy   <= 1'b0;
            cnt_i      <= '0;
            cnt_j      <= '0;
        end else begin
            bus.busy <= state != IDLE || count != '0;
            bus.plot <= draw_px;
            bus.done <= (state == LOAD && hempty) || (state == DRAW && last_i && last_j);
            if (draw_px) begin
                bus.plot_x <= sx[X_W-1:0];
                bus.plot_y <= sy[Y_W-1:0];
                bus.color  <= c;
            end
            if (state == LOAD) begin
                {mode, c, h, w, y, x} <= {hm, hc, hh, hw, hy, hx};
                cnt_i <= '0;
                cnt_j <= '0;
            end else if (state == DRAW) begin
                cnt_i <= last_i ? '0 : cnt_i + X_W'(1);
                if (last_i)
                    cnt_j <= cnt_j + Y_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rect_plot_engine.sv
// tb_rect_plot_engine: scoreboard bench; the model lists every expected pixel write and
// done pulse per command, and a negedge monitor matches them against the plot bus
module tb_rect_plot_engine;
    localparam int X_W = 8, Y_W = 7, COLOR_W = 3;

    typedef struct {
        bit p;
        int x;
        int y;
        int c;
        bit d;
    } ev_t;

    logic clk = 0;
    logic reset = 1;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    ev_t  exq[$];
    ev_t  mon_e;

    rect_plot_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

    rect_plot_engine #(
        .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .SCREEN_W(160), .SCREEN_H(120), .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // expected pixel writes in raster order; done rides on the last position if it is drawn
    task automatic model(input int x, y, w, h, c, m);
        bit last_drawn = 0;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                bit vis  = (x + i < 160) && (y + j < 120);
                bit edg  = m == 0 || i == 0 || i == w - 1 || j == 0 || j == h - 1;
                if (vis && edg) begin
                    exq.push_back('{1, x + i, y + j, c, 0});
                    last_drawn = (i == w - 1) && (j == h - 1);
                end
            end
        if (last_drawn) exq[exq.size() - 1].d = 1;
        else exq.push_back('{0, 0, 0, 0, 1});
    endtask

    task automatic send(input int x, y, w, h, c, m);
        int n = 0;
        @(negedge clk);
        bus.cmd_x     = X_W'(x);
        bus.cmd_y     = Y_W'(y);
        bus.cmd_w     = X_W'(w);
        bus.cmd_h     = Y_W'(h);
        bus.cmd_color = COLOR_W'(c);
        bus.cmd_mode  = m[0];
        bus.cmd_valid = 1;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", int'(bus.cmd_ready), 1);
        @(posedge clk);
        model(x, y, w, h, c, m);
        #1 bus.cmd_valid = 0;
    endtask

    task automatic wait_done(output int cyc, output int plots, output int first);
        cyc = 0;
        plots = 0;
        first = -1;
        @(negedge clk);
        while (!bus.done && cyc < 600) begin
            if (bus.plot) begin
                plots++;
                if (first < 0) first = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        if (bus.plot) begin
            plots++;
            if (first < 0) first = cyc;
        end
        chk("done_seen", int'(bus.done), 1);
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.plot || bus.done)) begin
            total++;
            if (bus.done) done_cnt++;
            if (exq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: plot=%0d x=%0d y=%0d done=%0d, expected nothing",
                         bus.plot, bus.plot_x, bus.plot_y, bus.done);
            end else begin
                mon_e = exq.pop_front();
                if (bus.plot !== mon_e.p || bus.done !== mon_e.d ||
                    (mon_e.p && (int'(bus.plot_x) != mon_e.x || int'(bus.plot_y) != mon_e.y ||
                                 int'(bus.color) != mon_e.c))) begin
                    bad++;
                    $display("FAIL pixel: got plot=%0d (%0d,%0d) c=%0d done=%0d, expected plot=%0d (%0d,%0d) c=%0d done=%0d",
                             bus.plot, bus.plot_x, bus.plot_y, bus.color, bus.done,
                             mon_e.p, mon_e.x, mon_e.y, mon_e.c, mon_e.d);
                end
            end
        end
    end

    initial begin
        int cyc, plots, first, n, base;
        bus.cmd_valid = 0;
        bus.cmd_x = 0; bus.cmd_y = 0; bus.cmd_w = 0; bus.cmd_h = 0;
        bus.cmd_color = 0; bus.cmd_mode = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_plot_x", int'(bus.plot_x), 0);
        chk("rst_plot_y", int'(bus.plot_y), 0);
        chk("rst_color", int'(bus.color), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready", int'(bus.cmd_ready), 1);

        send(10, 5, 3, 2, 4, 0);
        wait_done(cyc, plots, first);
        chk("fill_first_latency", first, 3);
        chk("fill_plots", plots, 6);
        chk("fill_done_cycle", cyc, 8);
        chk("fill_busy_at_done", int'(bus.busy), 1);
        @(negedge clk);
        chk("fill_busy_after", int'(bus.busy), 0);

        send(0, 0, 4, 3, 2, 1);
        wait_done(cyc, plots, first);
        chk("outline_plots", plots, 10);
        chk("outline_draw_cycles", cyc - first + 1, 12);

        send(158, 118, 4, 4, 5, 0);
        wait_done(cyc, plots, first);
        chk("clip_edge_plots", plots, 4);
        chk("clip_edge_cycle", cyc, 18);
        send(250, 0, 10, 2, 6, 0);
        wait_done(cyc, plots, first);
        chk("clip_carry_plots", plots, 0);
        chk("clip_carry_cycle", cyc, 22);

        send(5, 7, 0, 3, 1, 0);
        wait_done(cyc, plots, first);
        chk("empty_plots", plots, 0);
        chk("empty_done_cycle", cyc, 2);
        @(negedge clk);
        chk("empty_busy_after", int'(bus.busy), 0);

        base = done_cnt;
        send(20, 20, 20, 5, 3, 0);
        for (int k = 0; k < 4; k++)
            send($urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(1, 6),
                 $urandom_range(1, 5), $urandom_range(0, 7), $urandom_range(0, 1));
        chk("full_ready_low", int'(bus.cmd_ready), 0);
        send(100, 100, 3, 3, 7, 1);
        n = 0;
        while (done_cnt < base + 6 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("queue_done_pulses", done_cnt - base, 6);

        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        send(20, 20, 10, 10, 2, 0);
        send(30, 30, 2, 2, 4, 0);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 reset = 1;
        exq.delete();
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("abort_plot", int'(bus.plot), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_ready", int'(bus.cmd_ready), 1);
        plots = 0;
        repeat (150) begin
            @(negedge clk);
            plots += int'(bus.plot) + int'(bus.done);
        end
        chk("abort_quiet", plots, 0);

        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 12),
                 $urandom_range(0, 8), $urandom_range(0, 7), $urandom_range(0, 1));
        end
        n = 0;
        while ((exq.size() != 0 || bus.busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exq.size(), 0);
        chk("drain_busy", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
